// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the opcode constants, the state encoding (also exported on the debug
// port), the ALU operation codes, the datapath mux select codes, and the
// packed control word passed from the output decoder to the top level.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    // ALU operand B select: register B, constant 4, sign-extended imm,
    // sign-extended imm shifted left by 2 (branch offset).
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    // PC source select: ALU result, ALUOut register, jump target.
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_output_decode.sv
// Combinational state-to-control-word decoder for the multicycle control unit.
// Ports:
//   state_i      current FSM state
//   mem_ready_i  memory completion strobe (qualifies the FETCH PC/IR writes)
//   ctrl_o       datapath control word; every field not named for a state is 0
//   illegal_op_o high only in TRAP
module mips_ctrl_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_op_o
);

    always_comb begin
        ctrl_o       = '0;
        illegal_op_o = 1'b0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALU_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                // PC+4 and the IR capture only in the cycle memory delivers.
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.ir_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ctrl_o.alu_src_b = SRCB_BOFS;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALU_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALU_FUNC;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_REG;
                ctrl_o.alu_op        = ALU_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_OUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_TRAP: begin
                illegal_op_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: state register, next-state logic and the
// retired-instruction counter. Control strobes come from the output decoder.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   opcode                IR[31:26], valid from DECODE onward
//   mem_ready             memory completion strobe (FETCH, MEM_READ, MEM_WRITE)
//   pc_write .. alu_op    datapath control strobes
//   illegal_op            high while trapped on an illegal opcode
//   instr_retired         one-cycle pulse in the cycle an instruction retires
//   instr_count           retired-instruction count, wraps at 2^32
//   state                 current FSM state (debug)
// Handshake: memory accesses hold their strobes every cycle of the access and
// complete in the first cycle mem_ready is sampled high; no other handshake.
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit STRICT_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [1:0]  alu_op,
    output logic        illegal_op,
    output logic        instr_retired,
    output logic [31:0] instr_count,
    output logic [3:0]  state
);

    state_e      state_q, state_d;
    logic        retire;
    logic [31:0] instr_count_q;
    ctrl_t       ctrl_raw, ctrl;
    logic        illegal_raw;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        if (STRICT_ILLEGAL) begin
                            state_d = S_TRAP;
                        end else begin
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end
                    end
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instr_count_q <= instr_count_q + 32'd1;
        end
    end

    mips_ctrl_output_decode u_decode (
        .state_i      (state_q),
        .mem_ready_i  (mem_ready),
        .ctrl_o       (ctrl_raw),
        .illegal_op_o (illegal_raw)
    );

    // Reset silences every strobe immediately, not just from the next edge.
    assign ctrl          = reset ? '0 : ctrl_raw;
    assign illegal_op    = illegal_raw & ~reset;
    assign instr_retired = retire & ~reset;

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign pc_source     = ctrl.pc_source;
    assign alu_op        = ctrl.alu_op;
    assign instr_count   = instr_count_q;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode;
    logic        mem_ready;

    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_source, alu_op;
    logic        illegal_op, instr_retired;
    logic [31:0] instr_count;
    logic [3:0]  state;

    logic        ns_pc_write, ns_pc_write_cond, ns_i_or_d, ns_mem_read, ns_mem_write, ns_ir_write;
    logic        ns_mem_to_reg, ns_reg_dst, ns_reg_write, ns_alu_src_a;
    logic [1:0]  ns_alu_src_b, ns_pc_source, ns_alu_op;
    logic        ns_illegal_op, ns_instr_retired;
    logic [31:0] ns_instr_count;
    logic [3:0]  ns_state;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_count;

    multicycle_control_fsm #(.STRICT_ILLEGAL(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .alu_op(alu_op), .illegal_op(illegal_op), .instr_retired(instr_retired),
        .instr_count(instr_count), .state(state)
    );

    multicycle_control_fsm #(.STRICT_ILLEGAL(1'b0)) dut_ns (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(ns_pc_write), .pc_write_cond(ns_pc_write_cond), .i_or_d(ns_i_or_d),
        .mem_read(ns_mem_read), .mem_write(ns_mem_write), .ir_write(ns_ir_write),
        .mem_to_reg(ns_mem_to_reg), .reg_dst(ns_reg_dst), .reg_write(ns_reg_write),
        .alu_src_a(ns_alu_src_a), .alu_src_b(ns_alu_src_b), .pc_source(ns_pc_source),
        .alu_op(ns_alu_op), .illegal_op(ns_illegal_op), .instr_retired(ns_instr_retired),
        .instr_count(ns_instr_count), .state(ns_state)
    );

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op}
    logic [15:0] ctrl_w;
    assign ctrl_w = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, alu_op};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- expected control words (hand-written) ----------------
    function automatic logic [15:0] exp_word(input logic [3:0] st, input logic rdy);
        case (st)
            4'd0:    exp_word = rdy ? 16'b1001010000_01_00_00 : 16'b0001000000_01_00_00;
            4'd1:    exp_word = 16'b0000000000_11_00_00;
            4'd2:    exp_word = 16'b0000000001_10_00_00;
            4'd3:    exp_word = 16'b0011000000_00_00_00;
            4'd4:    exp_word = 16'b0000001010_00_00_00;
            4'd5:    exp_word = 16'b0010100000_00_00_00;
            4'd6:    exp_word = 16'b0000000001_00_00_10;
            4'd7:    exp_word = 16'b0000000110_00_00_00;
            4'd8:    exp_word = 16'b0100000001_00_01_01;
            4'd9:    exp_word = 16'b1000000000_00_10_00;
            4'd10:   exp_word = 16'b0000000001_10_00_00;
            4'd11:   exp_word = 16'b0000000010_00_00_00;
            default: exp_word = 16'h0000;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        reset     = 1'b1;
        opcode    = 6'd0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("reset_ctrl", {16'd0, ctrl_w}, 32'd0);
        chk("reset_retired", {31'd0, instr_retired}, 32'd0);
        chk("reset_illegal", {31'd0, illegal_op}, 32'd0);
        @(posedge clk); #1;
        reset     = 1'b0;
        exp_count = 32'd0;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_count", instr_count, 32'd0);
    endtask

    // path: nibble i = expected state in cycle i; rdy: bit i = mem_ready in cycle i
    typedef struct {
        logic [5:0]  op;
        int          len;
        logic [7:0]  rdy;
        logic [31:0] path;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        logic [3:0] st;
        for (int i = 0; i < v.len; i++) begin
            opcode    = v.op;
            mem_ready = v.rdy[i];
            st        = v.path[i*4 +: 4];
            @(negedge clk);
            chk($sformatf("v%0d_c%0d_state", idx, i), {28'd0, state}, {28'd0, st});
            chk($sformatf("v%0d_c%0d_ctrl", idx, i), {16'd0, ctrl_w}, {16'd0, exp_word(st, v.rdy[i])});
            chk($sformatf("v%0d_c%0d_retired", idx, i), {31'd0, instr_retired},
                (i == v.len - 1) ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_c%0d_illegal", idx, i), {31'd0, illegal_op}, 32'd0);
            @(posedge clk); #1;
        end
        exp_count = exp_count + 32'd1;
        chk($sformatf("v%0d_end_state", idx), {28'd0, state}, 32'd0);
        chk($sformatf("v%0d_end_count", idx), instr_count, exp_count);
    endtask

    vec_t vecs[9];

    // ---------------- test ----------------
    initial begin
        reset = 1'b1; opcode = 6'd0; mem_ready = 1'b1; exp_count = 32'd0;

        vecs[0] = '{6'b000000, 4, 8'hFF, 32'h0000_7610}; // R-type
        vecs[1] = '{6'b100011, 5, 8'hFF, 32'h0004_3210}; // lw
        vecs[2] = '{6'b101011, 4, 8'hFF, 32'h0000_5210}; // sw
        vecs[3] = '{6'b000100, 3, 8'hFF, 32'h0000_0810}; // beq
        vecs[4] = '{6'b000010, 3, 8'hFF, 32'h0000_0910}; // j
        vecs[5] = '{6'b001000, 4, 8'hFF, 32'h0000_BA10}; // addi
        vecs[6] = '{6'b100011, 7, 8'hE7, 32'h0433_3210}; // lw, read stalled 2
        vecs[7] = '{6'b000010, 6, 8'hF8, 32'h0091_0000}; // j, fetch stalled 3
        vecs[8] = '{6'b101011, 6, 8'hE7, 32'h0055_5210}; // sw, write stalled 2

        do_reset();
        for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

        // Illegal opcode: strict traps, non-strict retires as a NOP.
        do_reset();
        opcode = 6'b111111; mem_ready = 1'b1;
        @(negedge clk);
        chk("ill_c0_state", {28'd0, state}, 32'd0);
        chk("ill_ns_c0_state", {28'd0, ns_state}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ill_c1_state", {28'd0, state}, 32'd1);
        chk("ill_c1_retired", {31'd0, instr_retired}, 32'd0);
        chk("ill_ns_c1_state", {28'd0, ns_state}, 32'd1);
        chk("ill_ns_c1_retired", {31'd0, ns_instr_retired}, 32'd1);
        @(posedge clk); #1;
        chk("ill_ns_back_fetch", {28'd0, ns_state}, 32'd0);
        chk("ill_ns_count", ns_instr_count, 32'd1);
        for (int k = 0; k < 4; k++) begin
            mem_ready = k[0];
            @(negedge clk);
            chk($sformatf("trap%0d_state", k), {28'd0, state}, 32'd12);
            chk($sformatf("trap%0d_illegal", k), {31'd0, illegal_op}, 32'd1);
            chk($sformatf("trap%0d_ctrl", k), {16'd0, ctrl_w}, 32'd0);
            chk($sformatf("trap%0d_retired", k), {31'd0, instr_retired}, 32'd0);
            @(posedge clk); #1;
        end
        chk("trap_count", instr_count, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("trap_reset_illegal", {31'd0, illegal_op}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("trap_reset_state", {28'd0, state}, 32'd0);

        // Reset while waiting in MEM_WRITE aborts the store.
        do_reset();
        opcode = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        chk("mw_wait_state", {28'd0, state}, 32'd5);
        chk("mw_wait_write", {31'd0, mem_write}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mw_reset_write", {31'd0, mem_write}, 32'd0);
        chk("mw_reset_retired", {31'd0, instr_retired}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mw_after_state", {28'd0, state}, 32'd0);
        chk("mw_after_count", instr_count, 32'd0);

        // Counter wrap on retirement.
        do_reset();
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        exp_count = 32'hFFFF_FFFF;
        chk("wrap_preload", instr_count, exp_count);
        run_vec(4, vecs[4]);
        chk("wrap_zero", instr_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter STRICT_ILLEGAL, default 1, meaning an illegal opcode enters TRAP (1) or retires as a NOP (0).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port opcode, input, 6, instruction register bits [31:26], valid from DECODE onward.
REQ-005 SHALL have port mem_ready, input, 1, memory completion strobe sampled in the FETCH, MEM_READ and MEM_WRITE states.
REQ-006 SHALL have outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write and alu_src_a, each 1 bit, as datapath control strobes.
REQ-007 SHALL have outputs alu_src_b, pc_source and alu_op, each 2 bits; alu_op encodes 00=add, 01=sub, 10=func-decoded (consumed by the ALU-control decoder).
REQ-008 SHALL have outputs illegal_op (1 bit), instr_retired (1-bit pulse), instr_count (32 bits) and state (4 bits, debug).

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, TRAP=12.
REQ-010 SHALL behave in FETCH as follows:
- mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
- pc_write and ir_write asserted only in a cycle where mem_ready=1.
- Advance to DECODE on mem_ready=1; otherwise hold FETCH.
REQ-011 SHALL, in DECODE, drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target), then branch by opcode:
- 000000 -> EXECUTE
- 100011 or 101011 -> MEM_ADDR
- 000100 -> BRANCH
- 000010 -> JUMP
- 001000 -> ADDI_EXEC
- else -> TRAP if STRICT_ILLEGAL, otherwise FETCH with instr_retired.
REQ-012 SHALL, in MEM_ADDR, drive alu_src_a=1, alu_src_b=10, alu_op=00; go to MEM_READ for opcode 100011, otherwise MEM_WRITE.
REQ-013 SHALL, in MEM_READ, hold mem_read=1 and i_or_d=1 until mem_ready=1, then go to MEM_WB.
REQ-014 SHALL, in MEM_WRITE, hold mem_write=1 and i_or_d=1 until mem_ready=1, then retire.
REQ-015 SHALL, in MEM_WB, drive reg_write=1, mem_to_reg=1, reg_dst=0, then retire.
REQ-016 SHALL, in EXECUTE, drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to R_WB; R_WB drives reg_write=1, reg_dst=1, mem_to_reg=0, then retires.
REQ-017 SHALL, in BRANCH, drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, then retire.
REQ-018 SHALL, in JUMP, drive pc_write=1, pc_source=10, then retire.
REQ-019 SHALL, in ADDI_EXEC, drive alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB; ADDI_WB drives reg_write=1, reg_dst=0, mem_to_reg=0, then retires.
REQ-020 SHALL define "retire" as: the next state is FETCH, instr_retired=1 for exactly that cycle, and instr_count increments on that edge, wrapping 0xFFFFFFFF -> 0.
REQ-021 SHALL hold TRAP with illegal_op=1 and every other control output 0 until reset.
REQ-022 SHALL drive every output not named for the current state to 0; outputs are decoded from state, qualified by mem_ready where stated.
REQ-023 SHALL give zero-wait latencies in cycles of: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4; each cycle mem_ready is low adds one cycle.

Reset
REQ-024 SHALL, while reset=1, force all control outputs, illegal_op and instr_retired to 0; load state FETCH and instr_count 0 on the edge.
REQ-025 SHALL let reset asserted in any state, including TRAP or mid-wait, abort the instruction without retiring it; the first cycle after reset is FETCH.

Structure
REQ-026 SHALL place opcode constants, state encodings and alu_op codes in shared package mips_ctrl_pkg.
REQ-027 SHALL split the state-to-control-word decode into sub-module mips_ctrl_output_decode; the next-state register and counter stay in the top module.

Verification
REQ-028 SHALL test R-type: mem_ready held 1, opcode 000000 -> states 0,1,6,7,0; reg_write=1 only in R_WB; instr_count 0->1.
REQ-029 SHALL test lw with a stalled read: opcode 100011, mem_ready low 2 cycles in MEM_READ -> 7 cycles total; mem_read held high throughout the stall.
REQ-030 SHALL test FETCH stall: mem_ready low 3 cycles -> pc_write and ir_write stay 0 until the ready cycle, then pulse exactly once.
REQ-031 SHALL test illegal opcode 111111: STRICT_ILLEGAL=1 -> TRAP with illegal_op=1 held; STRICT_ILLEGAL=0 -> FETCH after 2 cycles with instr_retired=1.
REQ-032 SHALL test reset asserted during MEM_WRITE -> next state FETCH, mem_write=0 during reset, instr_count=0.
REQ-033 SHALL test wrap: preload instr_count 0xFFFFFFFF via force, retire a j (opcode 000010) -> instr_count=0.
